// File: rtl/exec_debug_controller_pkg.sv
// exec_debug_controller_pkg: shared state encoding and memory-owner constants.
package exec_debug_controller_pkg;
  typedef enum logic [5:0] {
    HALT     = 6'b000001,
    RUN      = 6'b000010,
    STEP     = 6'b000100,
    DRAIN    = 6'b001000,
    DBG_READ = 6'b010000,
    DBG_DONE = 6'b100000
  } state_t;
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;
  localparam int LAT_W = 4;
endpackage

// File: rtl/exec_debug_controller_edge_detect_rise.sv
// edge_detect_rise: one-cycle pulse on a rising edge of a synchronous level.
module edge_detect_rise (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) q <= 1'b0;
    else q <= d;
  end
  assign rise = d & ~q;
endmodule

// File: rtl/exec_debug_controller.sv
// exec_debug_controller: run/step/halt clock gating for the CPU, debug memory reads while halted,
// and a retired-instruction counter.
module exec_debug_controller
  import exec_debug_controller_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic              cpu_inst_done,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_enable,
  output logic              halted,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  inst_count
);
  state_t state;
  logic step_pending, step_rise;
  logic [ADDR_W-1:0] dbg_addr_q;
  logic [LAT_W-1:0] lat_cnt;
  edge_detect_rise u_step (.clock(clock), .reset(reset), .d(step_btn), .rise(step_rise));
  assign cpu_enable = state inside {RUN, STEP, DRAIN};
  assign halted     = state == HALT;
  assign mem_sel    = (state inside {DBG_READ, DBG_DONE}) ? OWNER_DBG : OWNER_CPU;
  assign dbg_ack    = state == DBG_DONE;
  assign mem_addr   = (mem_sel == OWNER_DBG) ? dbg_addr_q : cpu_addr;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= HALT;
      step_pending <= 1'b0;
      dbg_addr_q   <= '0;
      lat_cnt      <= '0;
      dbg_rdata    <= '0;
      inst_count   <= '0;
    end else begin
      if (cpu_enable && cpu_inst_done) inst_count <= inst_count + CNT_W'(1);
      case (state)
        HALT:
          if (dbg_req) begin
            state      <= DBG_READ;
            dbg_addr_q <= dbg_addr;
            lat_cnt    <= LAT_W'(MEM_LAT);
          end else if (step_pending) begin
            state        <= STEP;
            step_pending <= 1'b0;
          end else if (run_sw) begin
            state        <= RUN;
            step_pending <= 1'b0;
          end
        RUN:   if (!run_sw) state <= DRAIN;
        STEP:  if (cpu_inst_done) state <= HALT;
        DRAIN:
          if (cpu_inst_done) state <= HALT;
          else if (run_sw) begin
            state        <= RUN;
            step_pending <= 1'b0;
          end
        DBG_READ:
          if (lat_cnt == LAT_W'(1)) begin
            state     <= DBG_DONE;
            dbg_rdata <= mem_rdata;
          end else lat_cnt <= lat_cnt - LAT_W'(1);
        DBG_DONE: state <= HALT;
        default:  state <= HALT;
      endcase
      // a fresh press in the same cycle as a step/run entry is a new request, so it wins
      if (step_rise) step_pending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_exec_debug_controller.sv
// tb_exec_debug_controller: table-driven vectors plus hand sequences; debug reads checked via a scoreboard.
module tb_exec_debug_controller;
  logic clock = 0, reset = 1;
  logic run_sw = 0, step_btn = 0, cpu_inst_done = 0, dbg_req = 0;
  logic [7:0] cpu_addr = 8'h20, dbg_addr = 0;
  logic cpu_enable, halted, dbg_ack, mem_sel;
  logic [31:0] dbg_rdata, mem_rdata;
  logic [7:0] mem_addr;
  logic [15:0] inst_count;
  logic [31:0] mem [256];
  logic [31:0] p0, p1;
  logic [31:0] exp_q [$];
  int tests = 0, fails = 0;

  exec_debug_controller #(.ADDR_W(8), .MEM_LAT(3), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .run_sw(run_sw), .step_btn(step_btn),
    .cpu_inst_done(cpu_inst_done), .cpu_addr(cpu_addr), .cpu_enable(cpu_enable),
    .halted(halted), .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack),
    .dbg_rdata(dbg_rdata), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .inst_count(inst_count)
  );

  always #5 clock = ~clock;

  // memory with 3-cycle latency: two register stages, sampled on the third edge
  always @(posedge clock) begin
    p0 <= mem[mem_addr];
    p1 <= p0;
  end
  assign mem_rdata = p1;

  typedef struct {
    logic run, step, done, req;
    logic [7:0] addr;
    logic en, halt, sel, ack;
    logic [7:0] ma;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs [13];

  function automatic vec_t mk(logic run, logic step, logic done, logic req, logic [7:0] addr,
                              logic en, logic halt, logic sel, logic ack, logic [7:0] ma, logic [15:0] cnt);
    vec_t v;
    v.run = run; v.step = step; v.done = done; v.req = req; v.addr = addr;
    v.en = en; v.halt = halt; v.sel = sel; v.ack = ack; v.ma = ma; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset && dbg_ack) begin
      if (exp_q.size() == 0) check("unexpected_ack", {32'd0, dbg_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      else check("dbg_rdata", {32'd0, dbg_rdata}, {32'd0, exp_q.pop_front()});
    end
  end

  initial begin
    logic prev_req;
    bit got, en_seen;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i * 32'h0101;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h04] = 32'hCAFE0004;
    vecs[0]  = mk(0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h20, 0);
    vecs[1]  = mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h20, 0);
    vecs[2]  = mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h20, 0);
    vecs[3]  = mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h20, 0);
    vecs[4]  = mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h20, 0);
    vecs[5]  = mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h20, 0);
    vecs[6]  = mk(0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 8'h20, 1);
    vecs[7]  = mk(0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 8'h20, 1);
    vecs[8]  = mk(0, 0, 0, 1, 8'h10, 0, 0, 1, 0, 8'h10, 1);
    vecs[9]  = mk(0, 0, 0, 1, 8'h33, 0, 0, 1, 0, 8'h10, 1);
    vecs[10] = mk(0, 0, 0, 1, 8'h33, 0, 0, 1, 0, 8'h10, 1);
    vecs[11] = mk(0, 0, 0, 1, 8'h33, 0, 0, 1, 1, 8'h10, 1);
    vecs[12] = mk(0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h20, 1);

    repeat (3) @(posedge clock);
    #1;
    check("reset_state", {cpu_enable, halted, mem_sel, dbg_ack, dbg_rdata, inst_count},
          {4'b0100, 32'd0, 16'd0});
    reset = 0;
    prev_req = 0;
    for (int i = 0; i < 13; i++) begin
      run_sw = vecs[i].run; step_btn = vecs[i].step; cpu_inst_done = vecs[i].done;
      dbg_req = vecs[i].req; dbg_addr = vecs[i].addr;
      if (vecs[i].req && !prev_req) exp_q.push_back(mem[vecs[i].addr]);
      prev_req = vecs[i].req;
      tick();
      check($sformatf("vec%0d", i), {cpu_enable, halted, mem_sel, dbg_ack, mem_addr, inst_count},
            {vecs[i].en, vecs[i].halt, vecs[i].sel, vecs[i].ack, vecs[i].ma, vecs[i].cnt});
    end

    run_sw = 1;
    tick();
    check("run_entry", {cpu_enable, halted}, 2'b10);
    for (int i = 0; i < 20; i++) begin
      cpu_inst_done = (i % 4 == 3);
      tick();
    end
    run_sw = 0; cpu_inst_done = 0;
    tick();
    check("drain_hold1", {cpu_enable, halted, mem_sel}, 3'b100);
    tick();
    check("drain_hold2", {cpu_enable, halted, mem_sel}, 3'b100);
    cpu_inst_done = 1;
    tick();
    cpu_inst_done = 0;
    check("drain_halt", {cpu_enable, halted, inst_count}, {2'b01, 16'd7});

    run_sw = 1;
    tick();
    dbg_req = 1; dbg_addr = 8'h04;
    exp_q.push_back(mem[8'h04]);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("run_no_dbg", {mem_sel, dbg_ack, cpu_enable}, 3'b001);
    end
    run_sw = 0;
    tick();
    check("run_req_drain", {mem_sel, cpu_enable}, 2'b01);
    cpu_inst_done = 1;
    tick();
    cpu_inst_done = 0;
    check("run_req_halt", {halted, inst_count}, {1'b1, 16'd8});
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = dbg_ack;
    end
    check("run_read_ack", {63'd0, got}, 64'd1);
    dbg_req = 0;
    tick();
    check("run_read_back_halt", {halted, mem_sel}, 2'b10);

    dbg_req = 1; dbg_addr = 8'h10;
    tick();
    check("rst_read_started", {mem_sel, halted}, 2'b10);
    #2 reset = 1;
    #1;
    check("async_reset", {cpu_enable, halted, mem_sel, dbg_ack, dbg_rdata, inst_count},
          {4'b0100, 32'd0, 16'd0});
    dbg_req = 0;
    tick();
    reset = 0;
    repeat (6) tick();
    check("post_reset_idle", {halted, mem_sel, dbg_rdata}, {2'b10, 32'd0});

    step_btn = 1; dbg_req = 1; dbg_addr = 8'h10;
    exp_q.push_back(mem[8'h10]);
    tick();
    step_btn = 0;
    check("both_read_first", {mem_sel, cpu_enable}, 2'b10);
    got = 0; en_seen = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      en_seen |= cpu_enable;
      got = dbg_ack;
    end
    check("both_ack", {62'd0, got, en_seen}, 64'd2);
    dbg_req = 0;
    tick();
    check("both_halt_between", {halted, cpu_enable}, 2'b10);
    tick();
    check("both_step", {halted, cpu_enable}, 2'b01);
    tick();
    cpu_inst_done = 1;
    tick();
    cpu_inst_done = 0;
    check("both_step_done", {halted, cpu_enable, inst_count}, {2'b10, 16'd1});
    repeat (4) tick();
    check("single_step_only", {halted, cpu_enable, inst_count}, {2'b10, 16'd1});
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
